fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Core-side initiator that drives the private FPU's enable/operand interface and collects its result/valid/flags response. It accepts one FP request at a time from the core with a valid/ready handshake. It pulses the FPU enable for one cycle, waits for the FPU's valid, buffers the result until the core takes it, and maintains the sticky fflags CSR. It sits between the core's EX stage and the private FPU.

Parameters:
C_OP, 32, operand/result width
C_RM, 3, rounding-mode width
C_CMD, 4, FPU command width
C_PC, 5, div/sqrt precision-control width
C_FFLAG, 5, flag width, order {NV,DZ,OF,UF,NX}
C_FPU_DIV_CMD, fpu_defs::C_FPU_DIV_CMD, divide opcode
C_FPU_SQRT_CMD, fpu_defs::C_FPU_SQRT_CMD, sqrt opcode
C_TIMEOUT, 64, max cycles from enable pulse to FPU valid; must be >= 2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  controller can accept request
req_op_i  in  C_CMD  FPU command
req_a_i / req_b_i / req_c_i  in  C_OP each  operands
req_rm_i  in  C_RM  rounding mode
req_prec_i  in  C_PC  precision control
resp_valid_o  out  1  response available
resp_ready_i  in  1  core accepts response
resp_result_o  out  C_OP  result
resp_flags_o  out  C_FFLAG  flags of this op
resp_timeout_o  out  1  response produced by timeout
fpu_en_o  out  1  FPU enable pulse
fpu_op_o  out  C_CMD  to FPU
fpu_operand_a_o / fpu_operand_b_o / fpu_operand_c_o  out  C_OP each  to FPU
fpu_rm_o  out  C_RM; fpu_prec_o  out  C_PC  to FPU
fpu_result_i  in  C_OP; fpu_flags_i  in  C_FFLAG; fpu_valid_i  in  1  FPU response
divsqrt_busy_i  in  1  div/sqrt unit cannot accept a new op
fflags_we_i  in  1; fflags_wdata_i  in  C_FFLAG  CSR write
fflags_o  out  C_FFLAG  sticky accrued flags

Behaviour:
- Reset values: state IDLE; req_ready_o=1; resp_valid_o=0; fpu_en_o=0; all data outputs 0; fflags_o=0; timeout counter 0.
- Request registers (op, a, b, c, rm, prec) load on req_valid_i&req_ready_o. fpu_*_o are driven from these registers and stay stable from issue until the response is accepted.
- FSM IDLE -> ISSUE on accept. req_ready_o=1 only in IDLE.
- ISSUE: if the op is DIV or SQRT and divsqrt_busy_i=1, stall in ISSUE with fpu_en_o=0. Otherwise drive fpu_en_o=1 for exactly one cycle, clear the counter, and go to WAIT. Non-div/sqrt ops never stall on divsqrt_busy_i.
- WAIT: the counter increments each cycle.
  - On fpu_valid_i: latch fpu_result_i and fpu_flags_i, set resp_timeout_o=0, go to RESP.
  - If fpu_valid_i is absent when the counter reaches C_TIMEOUT-1: result=0, flags=5'b10000 (NV), resp_timeout_o=1, go to RESP.
  - fpu_valid_i on the same cycle as expiry counts as a normal response.
  - Minimum latency: fpu_valid_i may assert the cycle after fpu_en_o.
- RESP: resp_valid_o=1 and outputs are held. On resp_ready_i go to IDLE, so the next request is accepted the following cycle (no same-cycle re-accept). Total overhead is 1 cycle accept->enable and 1 cycle valid->resp_valid.
- fpu_valid_i outside WAIT is ignored: no state, flag, or result change.
- fflags: on the cycle the response is latched in WAIT, fflags_o <= fflags_o | latched flags.
  - fflags_we_i loads fflags_wdata_i.
  - If a CSR write and an accumulation occur in the same cycle, the CSR write wins.
- Reset mid-operation returns to IDLE and clears everything, including fflags_o. A later stale fpu_valid_i is ignored because the state is IDLE.

Test Plan:
- ADD, a=0x3F800000, b=0x40000000, FPU model returns 0x40400000 with flags 0 two cycles after enable -> fpu_en_o high exactly 1 cycle; resp_valid_o 3 cycles after fpu_en_o; result 0x40400000; fflags_o unchanged.
- DIV issued with divsqrt_busy_i=1 for 5 cycles -> fpu_en_o stays 0 for those 5 cycles and pulses on the first cycle busy is low. The same scenario with MUL issues immediately.
- Two back-to-back ops returning flags 5'b00001, then 5'b01000, with resp_ready_i=0 for 4 cycles on the first -> result held stable; req_ready_o=0 throughout; fflags_o=5'b01001 after the second.
- No fpu_valid_i with C_TIMEOUT=64 -> resp_valid_o 64 cycles after enable; result 0; flags 5'b10000; resp_timeout_o=1. A late fpu_valid_i in RESP/IDLE is ignored.
- fflags_we_i with wdata 5'b00000 on the same cycle a response with flags 5'b00100 is latched -> fflags_o=0. The next op with 5'b00100 gives fflags_o=5'b00100.
- rst_i asserted in WAIT, then fpu_valid_i two cycles later -> all outputs return to reset values; no response produced; req_ready_o=1.

Source files
------------

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: enable/operand request and result/valid/flags response bus to the private FPU
// Ports: master = issuing controller (drives en/op/a/b/c/rm/prec, receives result/flags/valid/divsqrt_busy),
//        slave  = FPU (the reverse directions)
interface fpu_issue_ctrl_if #(
    parameter int C_OP    = 32,
    parameter int C_RM    = 3,
    parameter int C_CMD   = 4,
    parameter int C_PC    = 5,
    parameter int C_FFLAG = 5
);
    logic               en;
    logic [C_CMD-1:0]   op;
    logic [C_OP-1:0]    a;
    logic [C_OP-1:0]    b;
    logic [C_OP-1:0]    c;
    logic [C_RM-1:0]    rm;
    logic [C_PC-1:0]    prec;
    logic [C_OP-1:0]    result;
    logic [C_FFLAG-1:0] flags;
    logic               valid;
    logic               divsqrt_busy;

    modport master (
        output en, op, a, b, c, rm, prec,
        input  result, flags, valid, divsqrt_busy
    );

    modport slave (
        input  en, op, a, b, c, rm, prec,
        output result, flags, valid, divsqrt_busy
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues one core FP request at a time to the private FPU and returns its response
// Ports: clk_i/rst_i clock and sync active-high reset; req_* core request (valid/ready handshake);
//        resp_* buffered response (valid/ready handshake, timeout marker); fpu FPU bus (master side);
//        fflags_we_i/fflags_wdata_i CSR write; fflags_o sticky accrued flags {NV,DZ,OF,UF,NX}
module fpu_issue_ctrl #(
    parameter int          C_OP           = 32,
    parameter int          C_RM           = 3,
    parameter int          C_CMD          = 4,
    parameter int          C_PC           = 5,
    parameter int          C_FFLAG        = 5,
    parameter int unsigned C_FPU_DIV_CMD  = 3,
    parameter int unsigned C_FPU_SQRT_CMD = 4,
    parameter int          C_TIMEOUT      = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [C_CMD-1:0]   req_op_i,
    input  logic [C_OP-1:0]    req_a_i,
    input  logic [C_OP-1:0]    req_b_i,
    input  logic [C_OP-1:0]    req_c_i,
    input  logic [C_RM-1:0]    req_rm_i,
    input  logic [C_PC-1:0]    req_prec_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [C_OP-1:0]    resp_result_o,
    output logic [C_FFLAG-1:0] resp_flags_o,
    output logic               resp_timeout_o,
    fpu_issue_ctrl_if.master   fpu,
    input  logic               fflags_we_i,
    input  logic [C_FFLAG-1:0] fflags_wdata_i,
    output logic [C_FFLAG-1:0] fflags_o
);
    localparam int CW = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [C_FFLAG-1:0] NV = {1'b1, {(C_FFLAG-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [C_CMD-1:0]   op_q;
    logic [C_OP-1:0]    a_q, b_q, c_q, result_q;
    logic [C_RM-1:0]    rm_q;
    logic [C_PC-1:0]    prec_q;
    logic [C_FFLAG-1:0] flags_q, fflags_q, fflags_d, new_flags;
    logic               timeout_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               accept, is_ds, fire, got, expire;

    always_comb begin
        accept    = req_valid_i && state_q == IDLE;
        is_ds     = op_q == C_CMD'(C_FPU_DIV_CMD) || op_q == C_CMD'(C_FPU_SQRT_CMD);
        fire      = state_q == ISSUE && !(is_ds && fpu.divsqrt_busy);
        got       = state_q == WAIT && fpu.valid;
        // cnt_q trails cycles-since-enable by one, so C_TIMEOUT-2 here puts the response
        // C_TIMEOUT cycles after the enable pulse
        expire    = state_q == WAIT && !fpu.valid && cnt_q == CW'(C_TIMEOUT - 2);
        new_flags = got ? fpu.flags : NV;
        cnt_d     = fire ? '0 : state_q == WAIT ? cnt_q + CW'(1) : cnt_q;
        fflags_d  = fflags_we_i ? fflags_wdata_i : (got || expire) ? fflags_q | new_flags : fflags_q;
        state_d   = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = fire ? WAIT : ISSUE;
            WAIT:    state_d = (got || expire) ? RESP : WAIT;
            RESP:    state_d = resp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            rm_q      <= '0;
            prec_q    <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            fflags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fflags_q <= fflags_d;
            if (accept) begin
                op_q   <= req_op_i;
                a_q    <= req_a_i;
                b_q    <= req_b_i;
                c_q    <= req_c_i;
                rm_q   <= req_rm_i;
                prec_q <= req_prec_i;
            end
            if (got || expire) begin
                result_q  <= got ? fpu.result : '0;
                flags_q   <= new_flags;
                timeout_q <= !got;
            end
        end
    end

    assign req_ready_o    = state_q == IDLE;
    assign resp_valid_o   = state_q == RESP;
    assign resp_result_o  = result_q;
    assign resp_flags_o   = flags_q;
    assign resp_timeout_o = timeout_q;
    assign fflags_o       = fflags_q;
    assign fpu.en         = fire;
    assign fpu.op         = op_q;
    assign fpu.a          = a_q;
    assign fpu.b          = b_q;
    assign fpu.c          = c_q;
    assign fpu.rm         = rm_q;
    assign fpu.prec       = prec_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: scoreboard bench for fpu_issue_ctrl with a behavioural FPU on the interface
module tb_fpu_issue_ctrl;
    localparam logic [3:0] ADD = 4'd0, MUL = 4'd2, DIV = 4'd3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0, req_ready_o;
    logic [3:0]  req_op_i = '0;
    logic [31:0] req_a_i = '0, req_b_i = '0, req_c_i = '0;
    logic [2:0]  req_rm_i = '0;
    logic [4:0]  req_prec_i = '0;
    logic        resp_valid_o, resp_ready_i = 1'b0, resp_timeout_o;
    logic [31:0] resp_result_o;
    logic [4:0]  resp_flags_o;
    logic        fflags_we_i = 1'b0;
    logic [4:0]  fflags_wdata_i = '0, fflags_o;

    fpu_issue_ctrl_if bus ();

    fpu_issue_ctrl #(.C_TIMEOUT(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
        .req_rm_i(req_rm_i), .req_prec_i(req_prec_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_result_o(resp_result_o),
        .resp_flags_o(resp_flags_o), .resp_timeout_o(resp_timeout_o),
        .fpu(bus.master),
        .fflags_we_i(fflags_we_i), .fflags_wdata_i(fflags_wdata_i), .fflags_o(fflags_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0;
    int cyc = 0, en_cnt = 0, en_cyc = 0, rv_cyc = 0, acc_cyc = 0;
    logic rv_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // cycle-stamped events for latency checks
    always @(negedge clk_i) begin
        cyc++;
        if (bus.en) begin
            en_cnt++;
            en_cyc = cyc;
        end
        if (req_valid_i && req_ready_o) acc_cyc = cyc;
        if (resp_valid_o && !rv_prev) rv_cyc = cyc;
        rv_prev = resp_valid_o;
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_op_i = op; req_a_i = a; req_b_i = b; req_c_i = a ^ b;
        req_rm_i = 3'd1; req_prec_i = 5'd3; req_valid_i = 1'b1;
        while (!req_ready_o && n < 50) begin tick(); n++; end
        tick();
        req_valid_i = 1'b0;
    endtask

    // lat = cycles from enable to fpu valid; 0 means the FPU never answers
    task automatic fpu_model(input int lat, input logic [31:0] a, input logic [31:0] res, input logic [4:0] flg);
        int n = 0;
        while (!bus.en && n < 50) begin @(posedge clk_i); #2; n++; end
        check("en_seen", bus.en, 1);
        if (!bus.en) return;
        check("fpu_a", bus.a, a);
        if (lat > 0) begin
            repeat (lat) @(posedge clk_i);
            #1;
            bus.valid = 1'b1; bus.result = res; bus.flags = flg;
            @(posedge clk_i);
            #1;
            bus.valid = 1'b0;
        end
    endtask

    task automatic get_resp(input int rdly, input bit late);
        int n = 0;
        exp_t e;
        while (!resp_valid_o && n < 200) begin tick(); n++; end
        check("resp_seen", resp_valid_o, 1);
        if (!resp_valid_o || sb.size() == 0) return;
        e = sb.pop_front();
        for (int i = 0; i < rdly; i++) begin
            if (late && i == 0) begin bus.valid = 1'b1; bus.result = 32'hDEADBEEF; bus.flags = 5'h1F; end
            if (i == 1) bus.valid = 1'b0;
            check("hold_result", resp_result_o, e.res);
            check("hold_ready", req_ready_o, 0);
            tick();
        end
        bus.valid = 1'b0;
        check("resp_valid", resp_valid_o, 1);
        check("resp_result", resp_result_o, e.res);
        check("resp_flags", resp_flags_o, e.flg);
        check("resp_timeout", resp_timeout_o, e.to);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check("ready_after", req_ready_o, 1);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] res, input logic [4:0] flg,
                         input logic [31:0] eres, input logic [4:0] eflg, input bit eto,
                         input int rdly, input bit late, input int e_issue, input int e_lat);
        int en0;
        exp_t e;
        e.res = eres; e.flg = eflg; e.to = eto;
        sb.push_back(e);
        en0 = en_cnt;
        fork
            begin issue(op, a, b); get_resp(rdly, late); end
            fpu_model(lat, a, res, flg);
        join
        check("en_pulses", en_cnt - en0, 1);
        check("issue_lat", en_cyc - acc_cyc, e_issue);
        check("resp_lat", rv_cyc - en_cyc, e_lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.valid = 1'b0; bus.result = '0; bus.flags = '0; bus.divsqrt_busy = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        check("rst_ready", req_ready_o, 1);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_en", bus.en, 0);
        check("rst_fflags", fflags_o, 0);
        check("rst_result", resp_result_o, 0);

        // plain add, 2-cycle FPU
        do_op(ADD, 32'h3F800000, 32'h40000000, 2, 32'h40400000, 5'h00,
              32'h40400000, 5'h00, 1'b0, 0, 1'b0, 1, 3);
        check("add_fflags", fflags_o, 0);

        // divide stalls while the div/sqrt unit is busy for 5 cycles
        bus.divsqrt_busy = 1'b1;
        fork
            do_op(DIV, 32'h40800000, 32'h40000000, 2, 32'h40000000, 5'h00,
                  32'h40000000, 5'h00, 1'b0, 0, 1'b0, 6, 3);
            begin
                n = 0;
                while (req_ready_o && n < 50) begin tick(); n++; end
                for (int i = 0; i < 5; i++) begin
                    check("div_stall_en", bus.en, 0);
                    tick();
                end
                bus.divsqrt_busy = 1'b0;
            end
        join

        // multiply ignores busy; minimum FPU latency
        bus.divsqrt_busy = 1'b1;
        do_op(MUL, 32'h40000000, 32'h40400000, 1, 32'h40C00000, 5'h00,
              32'h40C00000, 5'h00, 1'b0, 0, 1'b0, 1, 2);
        bus.divsqrt_busy = 1'b0;

        // back-to-back, first response held 4 cycles
        do_op(ADD, 32'h00000001, 32'h00000002, 2, 32'h11112222, 5'b00001,
              32'h11112222, 5'b00001, 1'b0, 4, 1'b0, 1, 3);
        do_op(MUL, 32'h00000003, 32'h00000004, 1, 32'h33334444, 5'b01000,
              32'h33334444, 5'b01000, 1'b0, 0, 1'b0, 1, 2);
        check("b2b_fflags", fflags_o, 5'b01001);

        // timeout with a late valid during RESP
        do_op(ADD, 32'h0000AAAA, 32'h0000BBBB, 0, 32'h0, 5'h0,
              32'h0, 5'b10000, 1'b1, 3, 1'b1, 1, 64);
        check("to_fflags", fflags_o, 5'b11001);

        // stale valid in IDLE
        bus.valid = 1'b1; bus.result = 32'hCAFEF00D; bus.flags = 5'h1F;
        tick();
        bus.valid = 1'b0;
        tick();
        check("idle_ready", req_ready_o, 1);
        check("idle_resp_valid", resp_valid_o, 0);
        check("idle_fflags", fflags_o, 5'b11001);
        check("idle_result", resp_result_o, 0);

        fflags_we_i = 1'b1; fflags_wdata_i = 5'b00000;
        tick();
        fflags_we_i = 1'b0;
        check("csr_clear", fflags_o, 0);

        // CSR write collides with accumulation
        fork
            do_op(ADD, 32'h00000005, 32'h00000006, 2, 32'h55556666, 5'b00100,
                  32'h55556666, 5'b00100, 1'b0, 0, 1'b0, 1, 3);
            begin
                n = 0;
                while (!bus.valid && n < 50) begin @(posedge clk_i); #2; n++; end
                fflags_we_i = 1'b1; fflags_wdata_i = 5'b00000;
                @(posedge clk_i);
                #1;
                fflags_we_i = 1'b0;
            end
        join
        check("csr_wins", fflags_o, 0);
        do_op(ADD, 32'h00000007, 32'h00000008, 2, 32'h77778888, 5'b00100,
              32'h77778888, 5'b00100, 1'b0, 0, 1'b0, 1, 3);
        check("csr_accum", fflags_o, 5'b00100);

        // reset in WAIT, then a stale valid
        fork
            issue(ADD, 32'h12345678, 32'h00000001);
            fpu_model(4, 32'h12345678, 32'h11111111, 5'h1F);
            begin
                n = 0;
                while (!bus.en && n < 50) begin tick(); n++; end
                tick();
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                check("mid_rst_ready", req_ready_o, 1);
                check("mid_rst_resp_valid", resp_valid_o, 0);
                check("mid_rst_en", bus.en, 0);
                check("mid_rst_fpu_a", bus.a, 0);
                check("mid_rst_fpu_op", bus.op, 0);
                check("mid_rst_result", resp_result_o, 0);
                check("mid_rst_flags", resp_flags_o, 0);
                check("mid_rst_timeout", resp_timeout_o, 0);
                check("mid_rst_fflags", fflags_o, 0);
            end
        join
        for (int i = 0; i < 3; i++) begin
            check("post_rst_resp_valid", resp_valid_o, 0);
            check("post_rst_ready", req_ready_o, 1);
            check("post_rst_fflags", fflags_o, 0);
            tick();
        end
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
